// File: rtl/alu_exec_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_exec_controller
//  Purpose  : Four-state sequencer (IDLE/READ/EXEC/WB) that drives the ALU and
//             register-file ports for one register/immediate instruction and
//             latches ALU flags into the 5-bit PSR {C, L, F, N, Z}.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_controller #(
   parameter int WIDTH_DATA    = 16,
   parameter int WIDTH_CONTROL = 4,
   parameter int WIDTH_ADDR    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [WIDTH_CONTROL-1:0] cmd_op,
   input  logic [WIDTH_ADDR-1:0]    cmd_rdest,
   input  logic [WIDTH_ADDR-1:0]    cmd_rsrc,
   input  logic [WIDTH_DATA-1:0]    cmd_imm,
   input  logic                     cmd_use_imm,
   input  logic                     cmd_use_carry,
   output logic [WIDTH_ADDR-1:0]    rf_raddr_a,
   output logic [WIDTH_ADDR-1:0]    rf_raddr_b,
   input  logic [WIDTH_DATA-1:0]    rf_rdata_a,
   input  logic [WIDTH_DATA-1:0]    rf_rdata_b,
   output logic                     rf_wen,
   output logic [WIDTH_ADDR-1:0]    rf_waddr,
   output logic [WIDTH_DATA-1:0]    rf_wdata,
   output logic [WIDTH_DATA-1:0]    alu_a,
   output logic [WIDTH_DATA-1:0]    alu_b,
   output logic [WIDTH_CONTROL-1:0] alu_control,
   output logic                     alu_carry_in,
   input  logic [WIDTH_DATA-1:0]    alu_result,
   input  logic                     alu_carry,
   input  logic                     alu_low,
   input  logic                     alu_over,
   input  logic                     alu_neg,
   input  logic                     alu_zero,
   output logic [4:0]               psr,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   localparam logic [WIDTH_CONTROL-1:0] c_op_add  = WIDTH_CONTROL'(0);
   localparam logic [WIDTH_CONTROL-1:0] c_op_addu = WIDTH_CONTROL'(1);
   localparam logic [WIDTH_CONTROL-1:0] c_op_sub  = WIDTH_CONTROL'(2);
   localparam logic [WIDTH_CONTROL-1:0] c_op_subu = WIDTH_CONTROL'(3);
   localparam logic [WIDTH_CONTROL-1:0] c_op_cmp  = WIDTH_CONTROL'(4);
   localparam logic [WIDTH_CONTROL-1:0] c_op_lsh  = WIDTH_CONTROL'(8);

   // PSR bit positions inside {C, L, F, N, Z}
   localparam int c_psr_c = 4;
   localparam int c_psr_l = 3;
   localparam int c_psr_f = 2;
   localparam int c_psr_n = 1;
   localparam int c_psr_z = 0;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [WIDTH_CONTROL-1:0]   r_op;
   logic [WIDTH_ADDR-1:0]      r_rdest;
   logic [WIDTH_ADDR-1:0]      r_rsrc;
   logic [WIDTH_DATA-1:0]      r_imm;
   logic                       r_use_imm;
   logic                       r_use_carry;
   logic [WIDTH_DATA-1:0]      r_result;
   logic [4:0]                 r_psr;
   logic [WIDTH_DATA-1:0]      r_alu_a;
   logic [WIDTH_DATA-1:0]      r_alu_b;
   logic [WIDTH_CONTROL-1:0]   r_alu_control;
   logic                       r_alu_carry_in;
   logic                       w_accept;
   logic                       w_op_legal;

   assign w_accept   = cmd_valid && (r_state == S_IDLE);
   assign w_op_legal = (r_op <= c_op_lsh);

   // Addresses and write data come straight from the captured command / result
   assign rf_raddr_a = r_rdest;
   assign rf_raddr_b = r_rsrc;
   assign rf_waddr   = r_rdest;
   assign rf_wdata   = r_result;
   assign psr        = r_psr;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state and output decode; ALU ports show held values outside EXEC
   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      rf_wen       = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      alu_a        = r_alu_a;
      alu_b        = r_alu_b;
      alu_control  = r_alu_control;
      alu_carry_in = r_alu_carry_in;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (w_accept) w_state_next = S_READ;
         end
         S_READ: w_state_next = S_EXEC;
         S_EXEC: begin
            alu_a        = rf_rdata_a;
            alu_b        = r_use_imm ? r_imm : rf_rdata_b;
            alu_control  = r_op;
            alu_carry_in = r_use_carry & r_psr[c_psr_c];
            w_state_next = S_WB;
         end
         S_WB: begin
            rf_wen       = w_op_legal && (r_op != c_op_cmp);
            done         = 1'b1;
            err          = !w_op_legal;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Command capture on handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op        <= '0;
         r_rdest     <= '0;
         r_rsrc      <= '0;
         r_imm       <= '0;
         r_use_imm   <= 1'b0;
         r_use_carry <= 1'b0;
      end else if (w_accept) begin
         r_op        <= cmd_op;
         r_rdest     <= cmd_rdest;
         r_rsrc      <= cmd_rsrc;
         r_imm       <= cmd_imm;
         r_use_imm   <= cmd_use_imm;
         r_use_carry <= cmd_use_carry;
      end
   end

   // Result register and ALU-port hold registers, loaded at the end of EXEC
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result       <= '0;
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_alu_control  <= '0;
         r_alu_carry_in <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_result       <= alu_result;
         r_alu_a        <= alu_a;
         r_alu_b        <= alu_b;
         r_alu_control  <= alu_control;
         r_alu_carry_in <= alu_carry_in;
      end
   end

   // PSR update at the end of EXEC; bits an op does not own keep their value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_psr <= 5'b0;
      end else if ((r_state == S_EXEC) && w_op_legal) begin
         r_psr[c_psr_n] <= alu_neg;
         r_psr[c_psr_z] <= alu_zero;
         case (r_op)
            c_op_add, c_op_sub:   r_psr[c_psr_f] <= alu_over;
            c_op_addu, c_op_subu: r_psr[c_psr_c] <= alu_carry;
            c_op_cmp:             r_psr[c_psr_l] <= alu_low;
            default:              ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_exec_controller
//  Purpose  : Directed bench for alu_exec_controller with a behavioural ALU
//             and a 16-entry register file (one-cycle read latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [3:0]  cmd_rdest;
   logic [3:0]  cmd_rsrc;
   logic [15:0] cmd_imm;
   logic        cmd_use_imm;
   logic        cmd_use_carry;
   logic [3:0]  rf_raddr_a, rf_raddr_b;
   logic [15:0] rf_rdata_a, rf_rdata_b;
   logic        rf_wen;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [15:0] alu_a, alu_b;
   logic [3:0]  alu_control;
   logic        alu_carry_in;
   logic [15:0] alu_result;
   logic        alu_carry, alu_low, alu_over, alu_neg, alu_zero;
   logic [4:0]  psr;
   logic        busy, done, err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_exec_controller #(.WIDTH_DATA(16), .WIDTH_CONTROL(4), .WIDTH_ADDR(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc), .cmd_imm(cmd_imm),
      .cmd_use_imm(cmd_use_imm), .cmd_use_carry(cmd_use_carry),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_carry_in(alu_carry_in), .alu_result(alu_result),
      .alu_carry(alu_carry), .alu_low(alu_low), .alu_over(alu_over),
      .alu_neg(alu_neg), .alu_zero(alu_zero),
      .psr(psr), .busy(busy), .done(done), .err(err)
   );

   // Register file model with a bench-side preload port
   logic [15:0] rf_mem [16];
   logic        pre_we = 1'b0;
   logic [3:0]  pre_addr = 4'd0;
   logic [15:0] pre_data = 16'd0;
   int          wen_cnt = 0;
   int          done_cnt = 0;

   always @(posedge clk) begin
      rf_rdata_a <= rf_mem[rf_raddr_a];
      rf_rdata_b <= rf_mem[rf_raddr_b];
      if (rf_wen)  rf_mem[rf_waddr] <= rf_wdata;
      if (pre_we)  rf_mem[pre_addr] <= pre_data;
      if (rf_wen)  wen_cnt  <= wen_cnt + 1;
      if (done)    done_cnt <= done_cnt + 1;
   end

   // Behavioural ALU: C is carry-out for add, borrow for subtract
   logic [16:0] m_s;
   always_comb begin
      m_s        = 17'd0;
      alu_result = 16'd0;
      alu_carry  = 1'b0;
      alu_low    = 1'b0;
      alu_over   = 1'b0;
      alu_neg    = 1'b0;
      alu_zero   = 1'b0;
      case (alu_control)
         4'd0, 4'd1: begin
            m_s        = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_carry_in};
            alu_result = m_s[15:0];
            alu_carry  = m_s[16];
            alu_over   = (alu_a[15] == alu_b[15]) && (m_s[15] != alu_a[15]);
         end
         4'd2, 4'd3: begin
            m_s        = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_carry_in};
            alu_result = m_s[15:0];
            alu_carry  = m_s[16];
            alu_over   = (alu_a[15] != alu_b[15]) && (m_s[15] != alu_a[15]);
         end
         4'd4: alu_result = alu_a - alu_b;
         4'd5: alu_result = alu_a & alu_b;
         4'd6: alu_result = alu_a | alu_b;
         4'd7: alu_result = alu_a ^ alu_b;
         4'd8: alu_result = alu_a << alu_b[3:0];
         default: alu_result = 16'd0;
      endcase
      if (alu_control == 4'd4) begin
         alu_low  = alu_a < alu_b;
         alu_neg  = $signed(alu_a) < $signed(alu_b);
         alu_zero = alu_a == alu_b;
      end else if (alu_control <= 4'd8) begin
         alu_neg  = alu_result[15];
         alu_zero = alu_result == 16'd0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [15:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   // One full instruction, called at a negedge while the DUT is IDLE
   task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [15:0] imm, input logic ui, input logic uc,
                            input logic exp_cin, input logic exp_wen, input logic [15:0] exp_wdata,
                            input logic exp_err, input logic [4:0] exp_psr);
      logic [15:0] exp_a, exp_b;
      exp_a = rf_mem[rd];
      exp_b = ui ? imm : rf_mem[rs];
      check("ready_idle", cmd_ready, 1'b1);
      cmd_op = op; cmd_rdest = rd; cmd_rsrc = rs; cmd_imm = imm;
      cmd_use_imm = ui; cmd_use_carry = uc; cmd_valid = 1'b1;
      @(negedge clk);                       // READ
      cmd_valid = 1'b0;
      check("read_ready", cmd_ready, 1'b0);
      check("read_raddr_a", rf_raddr_a, rd);
      @(negedge clk);                       // EXEC
      check("exec_alu_a", alu_a, exp_a);
      check("exec_alu_b", alu_b, exp_b);
      check("exec_ctrl", alu_control, op);
      check("exec_cin", alu_carry_in, exp_cin);
      check("exec_wen", rf_wen, 1'b0);
      @(negedge clk);                       // WB
      check("wb_wen", rf_wen, exp_wen);
      check("wb_done", done, 1'b1);
      check("wb_err", err, exp_err);
      check("wb_alu_a_hold", alu_a, exp_a);
      if (exp_wen) begin
         check("wb_waddr", rf_waddr, rd);
         check("wb_wdata", rf_wdata, exp_wdata);
      end
      @(negedge clk);                       // IDLE again
      check("post_done", done, 1'b0);
      check("post_err", err, 1'b0);
      check("post_psr", psr, exp_psr);
   endtask

   int base;

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rdest = 4'd0; cmd_rsrc = 4'd0;
      cmd_imm = 16'd0; cmd_use_imm = 1'b0; cmd_use_carry = 1'b0;
      for (int i = 0; i < 16; i++) rf_mem[i] = 16'd0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_wen", rf_wen, 1'b0);
      check("rst_psr", psr, 5'b0);
      check("rst_alu_a", alu_a, 16'd0);
      check("rst_alu_ctrl", alu_control, 4'd0);
      check("rst_wdata", rf_wdata, 16'd0);
      check("rst_raddr_a", rf_raddr_a, 4'd0);
      reset = 1'b0;
      @(negedge clk);

      // ADDU FFFF + 0001 -> 0000, C=1 Z=1
      preload(4'd1, 16'hFFFF);
      preload(4'd2, 16'h0001);
      base = done_cnt;
      run_instr(4'd1, 4'd1, 4'd2, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 5'b10001);
      check("addu_r1", rf_mem[1], 16'h0000);
      check("addu_done_once", done_cnt - base, 1);

      // Reset asserted during EXEC abandons the instruction
      preload(4'd1, 16'h0005);
      preload(4'd2, 16'h0003);
      base = wen_cnt;
      cmd_op = 4'd1; cmd_rdest = 4'd1; cmd_rsrc = 4'd2; cmd_use_imm = 1'b0;
      cmd_use_carry = 1'b0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rstx_exec_a", alu_a, 16'h0005);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstx_busy", busy, 1'b0);
      check("rstx_ready", cmd_ready, 1'b1);
      check("rstx_psr", psr, 5'b0);
      check("rstx_done", done, 1'b0);
      repeat (3) @(negedge clk);
      check("rstx_no_wen", wen_cnt - base, 0);
      check("rstx_r1", rf_mem[1], 16'h0005);

      // Set carry again, then ADD immediate overflow 7FFF + 1
      preload(4'd1, 16'hFFFF);
      preload(4'd2, 16'h0001);
      run_instr(4'd1, 4'd1, 4'd2, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 5'b10001);
      preload(4'd3, 16'h7FFF);
      run_instr(4'd0, 4'd3, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 5'b10110);
      // ADD with carry: 7FFE + 0 + 1 = 7FFF, no signed overflow so F clears
      preload(4'd3, 16'h7FFE);
      run_instr(4'd0, 4'd3, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b0, 5'b10000);
      // ADD with carry: 7FFF + 0 + 1 = 8000, overflow raised by the carry
      preload(4'd3, 16'h7FFF);
      run_instr(4'd0, 4'd3, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0, 5'b10110);

      // CMP 0 vs 1: L=1 N=1 Z=0, no write-back
      preload(4'd4, 16'h0000);
      preload(4'd5, 16'h0001);
      base = wen_cnt;
      run_instr(4'd4, 4'd4, 4'd5, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b11110);
      check("cmp_no_wen", wen_cnt - base, 0);
      check("cmp_r4", rf_mem[4], 16'h0000);

      // Back-to-back with cmd_valid held: SUBU then XOR imm FFFF on updated R6
      preload(4'd6, 16'h1234);
      preload(4'd7, 16'h0034);
      cmd_op = 4'd3; cmd_rdest = 4'd6; cmd_rsrc = 4'd7; cmd_imm = 16'h0000;
      cmd_use_imm = 1'b0; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
      check("b2b_ready0", cmd_ready, 1'b1);
      @(negedge clk);                       // READ of SUBU
      cmd_op = 4'd7; cmd_imm = 16'hFFFF; cmd_use_imm = 1'b1;
      check("b2b_ready1", cmd_ready, 1'b0);
      @(negedge clk);                       // EXEC of SUBU
      check("b2b_ctrl_subu", alu_control, 4'd3);
      check("b2b_ready2", cmd_ready, 1'b0);
      @(negedge clk);                       // WB of SUBU
      check("b2b_wen_subu", rf_wen, 1'b1);
      check("b2b_wdata_subu", rf_wdata, 16'h1200);
      check("b2b_ready3", cmd_ready, 1'b0);
      @(negedge clk);                       // IDLE, cycle 4: XOR accepted here
      check("b2b_ready4", cmd_ready, 1'b1);
      check("b2b_psr_subu", psr, 5'b01100);
      @(negedge clk);                       // READ of XOR
      cmd_valid = 1'b0;
      check("b2b_busy_xor", busy, 1'b1);
      @(negedge clk);                       // EXEC of XOR
      check("b2b_xor_a", alu_a, 16'h1200);
      check("b2b_ctrl_xor", alu_control, 4'd7);
      @(negedge clk);                       // WB of XOR
      check("b2b_wdata_xor", rf_wdata, 16'hEDFF);
      @(negedge clk);
      check("b2b_psr_xor", psr, 5'b01110);
      check("b2b_r6", rf_mem[6], 16'hEDFF);

      // Illegal op 9: err + done, PSR held, no write
      base = wen_cnt;
      run_instr(4'd9, 4'd6, 4'd7, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 5'b01110);
      check("ill_no_wen", wen_cnt - base, 0);
      check("ill_r6", rf_mem[6], 16'hEDFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
